// File: rtl/par_ar_arbiter.sv
// Read-address arbiter: round-robin grant of the shared AR channel, then holds
// the route until the R burst ends on RLAST, flagging burst-length violations.
module par_ar_arbiter #(
  parameter int MasterCount = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [MasterCount-1:0]   ARVALID_MS,
  input  logic [MasterCount*4-1:0] ARLEN_MS,
  input  logic                     ARREADY,
  input  logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     RLAST,
  output logic [MasterCount-1:0]   ARsel_Master,
  output logic [1:0]               state,
  output logic [MasterCount-1:0]   ARREADY_MS,
  output logic [MasterCount-1:0]   Rsel_Master,
  output logic                     rlast_err
);

  localparam int IW = (MasterCount > 1) ? $clog2(MasterCount) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARTRANS = 2'd1;
  localparam logic [1:0] RTRANS  = 2'd2;

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [IW-1:0]          ptr_r;
  logic [IW-1:0]          grant_idx_r;
  logic [MasterCount-1:0] grant_r;
  logic [3:0]             len_r;
  logic [3:0]             count_r;
  logic                   err_r;

  logic [IW-1:0]          grant_idx_s;
  logic [MasterCount-1:0] grant_s;
  logic                   any_req_s;
  logic [IW-1:0]          cand_s;
  logic                   hit_s;
  logic                   beat_s;

  // Index base+offset wrapped into 0..MasterCount-1 (offset < MasterCount).
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= MasterCount) begin
      sum = sum - MasterCount;
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction

  assign beat_s    = RVALID & RREADY;
  assign state     = state_r;
  assign rlast_err = err_r;

  // Round-robin search from ptr_r: first requesting master wins.
  always_comb begin
    grant_s     = {MasterCount{1'b0}};
    grant_idx_s = {IW{1'b0}};
    any_req_s   = 1'b0;
    cand_s      = {IW{1'b0}};
    hit_s       = 1'b0;
    for (int i = 0; i < MasterCount; i++) begin
      cand_s          = rr_index(ptr_r, i);
      hit_s           = !any_req_s && ARVALID_MS[cand_s];
      grant_idx_s     = hit_s ? cand_s : grant_idx_s;
      grant_s[cand_s] = grant_s[cand_s] | hit_s;
      any_req_s       = any_req_s | hit_s;
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; IDLE never re-grants on the cycle a burst ends.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ARREADY ? RTRANS : ARTRANS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARTRANS: state_nxt_s = ARREADY ? RTRANS : ARTRANS;
      RTRANS: begin
        if (beat_s && RLAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RTRANS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs; the IDLE grant stays combinational so it is live during reset.
  always_comb begin
    ARsel_Master = {MasterCount{1'b0}};
    ARREADY_MS   = {MasterCount{1'b0}};
    Rsel_Master  = {MasterCount{1'b0}};
    case (state_r)
      IDLE: begin
        ARsel_Master = grant_s;
        ARREADY_MS   = (ARREADY && ARESETn) ? grant_s : {MasterCount{1'b0}};
      end
      ARTRANS: begin
        ARsel_Master = grant_r;
        ARREADY_MS   = ARREADY ? grant_r : {MasterCount{1'b0}};
      end
      RTRANS: begin
        ARsel_Master = grant_r;
        Rsel_Master  = grant_r;
      end
      default: begin
        ARsel_Master = {MasterCount{1'b0}};
      end
    endcase
  end

  // Grant capture, beat counting, pointer advance and sticky length error.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_r     <= {MasterCount{1'b0}};
      grant_idx_r <= {IW{1'b0}};
      ptr_r       <= {IW{1'b0}};
      len_r       <= 4'd0;
      count_r     <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r     <= grant_s;
            grant_idx_r <= grant_idx_s;
            len_r       <= ARLEN_MS[{grant_idx_s, 2'b00} +: 4];
            count_r     <= 4'd0;
          end
        end
        RTRANS: begin
          if (beat_s) begin
            if (RLAST) begin
              count_r <= 4'd0;
              ptr_r   <= rr_index(grant_idx_r, 1);
              if (count_r != len_r) begin
                err_r <= 1'b1;
              end
            end else if (count_r == len_r) begin
              // Overrun: hold the count and keep waiting for RLAST.
              err_r <= 1'b1;
            end else begin
              count_r <= count_r + 4'd1;
            end
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_ar_arbiter.sv
// Self-checking bench for par_ar_arbiter: behavioural model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_par_ar_arbiter;

  localparam int MC = 2;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [1:0] ARVALID_MS;
  logic [7:0] ARLEN_MS;
  logic       ARREADY, RVALID, RREADY, RLAST;
  logic [1:0] ARsel_Master, state, ARREADY_MS, Rsel_Master;
  logic       rlast_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: who owns the channel, whether the address went out,
  // beats seen so far, and the round-robin start point.
  bit m_busy, m_addr_done, m_err;
  int m_master, m_len, m_cnt, m_ptr, m_burst_beats, m_done_beats;
  int grant_log[$];

  par_ar_arbiter #(.MasterCount(MC)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID_MS(ARVALID_MS), .ARLEN_MS(ARLEN_MS),
    .ARREADY(ARREADY), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .ARsel_Master(ARsel_Master), .state(state), .ARREADY_MS(ARREADY_MS),
    .Rsel_Master(Rsel_Master), .rlast_err(rlast_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [1:0] v);
    for (int k = 0; k < MC; k++) begin
      if (v[(p + k) % MC]) return (p + k) % MC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_addr_done = 0; m_err = 0; m_master = 0;
    m_len = 0; m_cnt = 0; m_ptr = 0; m_burst_beats = 0;
  endtask

  task automatic model_step();
    int g;
    if (!ARESETn) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      g = rr(m_ptr, ARVALID_MS);
      if (g >= 0) begin
        m_busy = 1; m_master = g; m_len = ARLEN_MS[g*4 +: 4];
        m_cnt = 0; m_burst_beats = 0; m_addr_done = ARREADY;
        grant_log.push_back(g);
      end
    end else if (!m_addr_done) begin
      m_addr_done = ARREADY;
    end else if (RVALID && RREADY) begin
      m_burst_beats++;
      if (RLAST) begin
        if (m_cnt != m_len) m_err = 1;
        m_busy = 0; m_addr_done = 0;
        m_ptr = (m_master + 1) % MC;
        m_done_beats = m_burst_beats;
      end else if (m_cnt == m_len) begin
        m_err = 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    int g;
    logic [1:0] e_sel, e_ardy, e_rsel, e_state;
    g = rr(m_ptr, ARVALID_MS);
    e_state = !m_busy ? 2'd0 : (m_addr_done ? 2'd2 : 2'd1);
    if (m_busy) e_sel = 2'(1 << m_master);
    else        e_sel = (g >= 0) ? 2'(1 << g) : 2'b00;
    e_ardy = (ARESETn && ARREADY && e_state != 2'd2) ? e_sel : 2'b00;
    e_rsel = (e_state == 2'd2) ? e_sel : 2'b00;
    chk("cyc_state", state, e_state);
    chk("cyc_arsel", ARsel_Master, e_sel);
    chk("cyc_arready_ms", ARREADY_MS, e_ardy);
    chk("cyc_rsel", Rsel_Master, e_rsel);
    chk("cyc_rlast_err", rlast_err, m_err);
  endtask

  always @(negedge ACLK) begin
    if (chk_en) compare_all();
  end

  task automatic cyc();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  task automatic clr_r();
    RVALID = 0; RREADY = 0; RLAST = 0;
  endtask

  // Finish whatever burst the model holds with single-beat RLAST traffic.
  task automatic drain();
    ARVALID_MS = 2'b00; ARREADY = 1; RVALID = 1; RREADY = 1; RLAST = 1;
    for (int i = 0; i < 8 && m_busy; i++) cyc();
    if (m_busy) chk("drain_timeout", 32'd1, 32'd0);
    ARREADY = 0; clr_r();
  endtask

  initial begin
    int sent;
    ARESETn = 0; ARVALID_MS = 2'b00; ARLEN_MS = 8'h00; ARREADY = 0; clr_r();
    model_reset();
    chk_en = 1;
    repeat (2) cyc();
    chk("rst_state", state, 2'd0);
    chk("rst_rsel", Rsel_Master, 2'b00);
    chk("rst_err", rlast_err, 1'b0);
    ARVALID_MS = 2'b10; ARREADY = 1; #1;
    chk("rst_arsel_comb", ARsel_Master, 2'b10);
    chk("rst_ardy_zero", ARREADY_MS, 2'b00);
    ARVALID_MS = 2'b00; ARREADY = 0;
    ARESETn = 1;
    repeat (2) cyc();

    // Both request with ARREADY in the same cycle: M0 wins and skips ARTRANS.
    ARVALID_MS = 2'b11; ARLEN_MS = 8'h00; ARREADY = 1; #1;
    chk("both_req_arsel", ARsel_Master, 2'b01);
    chk("both_req_ardy", ARREADY_MS, 2'b01);
    cyc();
    chk("idle_to_rtrans", state, 2'd2);
    chk("rsel_m0", Rsel_Master, 2'b01);
    ARREADY = 0; RVALID = 1; RREADY = 1; RLAST = 1;
    cyc();
    chk("rlast_to_idle", state, 2'd0);
    clr_r(); #1;
    chk("next_grant_m1", ARsel_Master, 2'b10);
    ARVALID_MS = 2'b00;
    cyc();

    // M1 alone, ARREADY held off for three ARTRANS cycles.
    ARVALID_MS = 2'b10; ARREADY = 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("artrans_state", state, 2'd1);
      chk("artrans_ardy", ARREADY_MS, 2'b00);
      ARVALID_MS = (i == 0) ? 2'b01 : 2'b00; #1;
      chk("artrans_sel_stable", ARsel_Master, 2'b10);
      if (i < 2) cyc();
    end
    ARREADY = 1; #1;
    chk("artrans_ardy_on", ARREADY_MS, 2'b10);
    cyc();
    chk("artrans_to_rtrans", state, 2'd2);
    drain();

    // ARLEN=3, four beats with RREADY toggling.
    ARVALID_MS = 2'b01; ARLEN_MS = 8'h03; ARREADY = 1;
    cyc();
    ARVALID_MS = 2'b00; ARREADY = 0;
    chk("burst_rtrans", state, 2'd2);
    sent = 0; RVALID = 1;
    for (int k = 0; k < 16 && sent < 4; k++) begin
      RREADY = k[0];
      RLAST = (sent == 3);
      if (RREADY) sent++;
      cyc();
      if (sent < 4) chk("burst_wait", state, 2'd2);
    end
    clr_r();
    chk("burst_idle", state, 2'd0);
    chk("burst_err", rlast_err, 1'b0);
    chk("burst_beats_model", m_done_beats, 32'd4);

    // ARLEN=1 but RLAST on the first beat.
    ARVALID_MS = 2'b01; ARLEN_MS = 8'h01; ARREADY = 1;
    cyc();
    ARVALID_MS = 2'b00; ARREADY = 0; RVALID = 1; RREADY = 1; RLAST = 1;
    cyc();
    clr_r();
    chk("early_last_err", rlast_err, 1'b1);
    chk("early_last_idle", state, 2'd0);
    ARLEN_MS = 8'h00; ARVALID_MS = 2'b01; ARREADY = 1;
    cyc();
    drain();
    chk("err_sticky", rlast_err, 1'b1);

    // Reset pulse mid-RTRANS while pointer favours M1.
    ARVALID_MS = 2'b10; ARREADY = 1;
    cyc();
    ARVALID_MS = 2'b11; ARREADY = 0;
    chk("pre_rst_rsel", Rsel_Master, 2'b10);
    #2;
    ARESETn = 0; model_reset(); #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_rsel", Rsel_Master, 2'b00);
    chk("async_rst_err", rlast_err, 1'b0);
    chk("async_rst_arsel_m0", ARsel_Master, 2'b01);
    cyc();
    ARESETn = 1; ARREADY = 1;
    cyc();
    chk("post_rst_state", state, 2'd2);
    chk("post_rst_grant_m0", Rsel_Master, 2'b01);
    drain();
    ARVALID_MS = 2'b10; ARREADY = 1;
    cyc();
    drain();

    // Continuous contention for six bursts.
    grant_log.delete();
    ARVALID_MS = 2'b11; ARLEN_MS = 8'h00; ARREADY = 1; RVALID = 1; RREADY = 1; RLAST = 1;
    repeat (12) cyc();
    ARVALID_MS = 2'b00; ARREADY = 0; clr_r();
    chk("rr_count", grant_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_grant", grant_log[i], i % 2);
    drain();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      ARVALID_MS    = 2'($urandom_range(0, 3));
      ARLEN_MS[3:0] = 4'($urandom_range(0, 3));
      ARLEN_MS[7:4] = 4'($urandom_range(0, 3));
      ARREADY = ($urandom_range(0, 99) < 60);
      RVALID  = ($urandom_range(0, 99) < 70);
      RREADY  = ($urandom_range(0, 99) < 70);
      RLAST   = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 299) == 0) begin
        ARESETn = 0;
        model_reset();
      end else begin
        ARESETn = 1;
      end
      cyc();
    end
    ARESETn = 1;
    drain();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
